// File: rtl/mipi_csi_pkg.sv
// Shared types and constants for the CSI-2 RX packet decoder (4 lanes x 16 bits).
package mipi_csi_pkg;

   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned LANE_W         = 16;
   localparam int unsigned NUM_LANES      = 4;
   localparam int unsigned BYTES_PER_LANE = LANE_W / BYTE_W;
   localparam int unsigned DATA_W         = LANE_W * NUM_LANES;
   localparam int unsigned BE_W           = DATA_W / BYTE_W;
   localparam int unsigned WC_W           = 16;
   localparam int unsigned DT_W           = 6;
   localparam int unsigned VC_W           = 2;
   localparam int unsigned ECC_W          = 6;
   localparam int unsigned HDR_W          = WC_W + BYTE_W;

   localparam logic [BYTE_W-1:0] SYNC_BYTE   = 8'hB8;
   localparam logic [DT_W-1:0]   LONG_DT_MIN = 6'h10;

   localparam logic [DT_W-1:0] DT_FS    = 6'h00;
   localparam logic [DT_W-1:0] DT_FE    = 6'h01;
   localparam logic [DT_W-1:0] DT_RAW8  = 6'h2A;
   localparam logic [DT_W-1:0] DT_RAW10 = 6'h2B;
   localparam logic [DT_W-1:0] DT_RAW12 = 6'h2C;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      DRAIN   = 2'd2
   } state_e;

   // Header fields covered by the ECC, DI in the low byte
   typedef struct packed {
      logic [WC_W-1:0]   wc;
      logic [BYTE_W-1:0] di;
   } hdr_t;

   // Byte enables for the last, partial payload word (n = 1..8)
   function automatic logic [BE_W-1:0] tail_mask(input logic [3:0] n);
      return BE_W'((9'd1 << n) - 9'd1);
   endfunction

endpackage

// File: rtl/mipi_csi_header_ecc.sv
// Combinational CSI-2 header ECC: 6-bit Hamming code over {WC, DI}.
module mipi_csi_header_ecc
   import mipi_csi_pkg::*;
(
   input  logic [HDR_W-1:0] hdr_i,
   output logic [ECC_W-1:0] ecc_c
);

   // Parity-bit coverage masks, bit k of the ECC uses ECC_MASK[k]
   localparam logic [HDR_W-1:0] ECC_MASK [ECC_W] = '{
      24'hF12CB7, 24'hF2555B, 24'h749A6D,
      24'hB8E38E, 24'hDF03F0, 24'hEFFC00
   };

   // Each ECC bit is the parity of its covered header bits
   always_comb begin
      for (int k = 0; k < ECC_W; k++) begin
         ecc_c[k] = ^(hdr_i & ECC_MASK[k]);
      end
   end

endmodule

// File: rtl/mipi_csi_rx_packet_decoder_16b4lane.sv
// CSI-2 RX packet decoder behind the 4-lane 16-bit lane aligner: sync check,
// header parse, payload reorder to stream order, FS/FE pulses.
// Optional header ECC check and header_err_o: define MIPI_CSI_RX_HEADER_ECC_EN.
module mipi_csi_rx_packet_decoder_16b4lane #(
   parameter logic [7:0] SYNC_BYTE   = mipi_csi_pkg::SYNC_BYTE,
   parameter logic [5:0] LONG_DT_MIN = mipi_csi_pkg::LONG_DT_MIN
) (
   input  logic                                clk_i,
   input  logic                                reset_n_i,
   input  logic                                data_valid_i,
   input  logic [mipi_csi_pkg::DATA_W-1:0]     data_i,
   output logic                                output_valid_o,
   output logic [mipi_csi_pkg::DATA_W-1:0]     data_o,
   output logic [mipi_csi_pkg::BE_W-1:0]       byte_en_o,
   output logic [mipi_csi_pkg::DT_W-1:0]       packet_type_o,
   output logic [mipi_csi_pkg::VC_W-1:0]       vc_o,
   output logic [mipi_csi_pkg::WC_W-1:0]       word_count_o,
   output logic                                frame_start_o,
   output logic                                frame_end_o,
`ifdef MIPI_CSI_RX_HEADER_ECC_EN
   output logic                                header_err_o,
`endif
   output logic                                abort_o
);

   import mipi_csi_pkg::BYTE_W;
   import mipi_csi_pkg::LANE_W;
   import mipi_csi_pkg::NUM_LANES;
   import mipi_csi_pkg::BYTES_PER_LANE;
   import mipi_csi_pkg::DATA_W;
   import mipi_csi_pkg::BE_W;
   import mipi_csi_pkg::WC_W;
   import mipi_csi_pkg::DT_W;
   import mipi_csi_pkg::VC_W;
   import mipi_csi_pkg::DT_FS;
   import mipi_csi_pkg::DT_FE;
   import mipi_csi_pkg::hdr_t;
   import mipi_csi_pkg::state_e;
   import mipi_csi_pkg::IDLE;
   import mipi_csi_pkg::PAYLOAD;
   import mipi_csi_pkg::DRAIN;
   import mipi_csi_pkg::tail_mask;

   state_e              state_q, state_d;
   logic                valid_prev_q, valid_prev_d;
   logic [WC_W-1:0]     rem_q, rem_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [BE_W-1:0]     byte_en_q, byte_en_d;
   logic [DT_W-1:0]     pt_q, pt_d;
   logic [VC_W-1:0]     vc_q, vc_d;
   logic [WC_W-1:0]     wc_q, wc_d;
   logic                fs_q, fs_d;
   logic                fe_q, fe_d;
   logic                abort_q, abort_d;

   hdr_t                hdr_c;
   logic                sync_ok_c;
   logic                rise_c;
   logic                hdr_ok_c;
   logic [DATA_W-1:0]   stream_c;

   assign hdr_c  = {data_i[47:40], data_i[31:24], data_i[15:8]};
   assign rise_c = data_valid_i & ~valid_prev_q;

   // Sync-byte check and lane-order to stream-order byte shuffle
   always_comb begin
      sync_ok_c = 1'b1;
      stream_c  = '0;
      for (int n = 0; n < NUM_LANES; n++) begin
         if (data_i[LANE_W*n +: BYTE_W] != SYNC_BYTE) sync_ok_c = 1'b0;
         for (int j = 0; j < BYTES_PER_LANE; j++) begin
            stream_c[BYTE_W*(NUM_LANES*j+n) +: BYTE_W] = data_i[LANE_W*n+BYTE_W*j +: BYTE_W];
         end
      end
   end

`ifdef MIPI_CSI_RX_HEADER_ECC_EN
   logic [mipi_csi_pkg::ECC_W-1:0] ecc_calc_c;
   logic [BYTE_W-1:0]              ecc_rx_c;
   logic                           hdr_err_q, hdr_err_d;

   assign ecc_rx_c = data_i[63:56];

   mipi_csi_header_ecc u_hdr_ecc (
      .hdr_i (hdr_c),
      .ecc_c (ecc_calc_c)
   );

   assign hdr_ok_c     = (ecc_rx_c[7:6] == 2'b00) && (ecc_rx_c[5:0] == ecc_calc_c);
   assign header_err_o = hdr_err_q;
`else
   assign hdr_ok_c = 1'b1;
`endif

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      valid_prev_d = data_valid_i;
      rem_d        = rem_q;
      out_valid_d  = 1'b0;
      data_d       = data_q;
      byte_en_d    = '0;
      pt_d         = pt_q;
      vc_d         = vc_q;
      wc_d         = wc_q;
      fs_d         = 1'b0;
      fe_d         = 1'b0;
      abort_d      = 1'b0;
`ifdef MIPI_CSI_RX_HEADER_ECC_EN
      hdr_err_d    = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (rise_c) begin
               if (!sync_ok_c) begin
                  state_d = DRAIN;
               end else if (!hdr_ok_c) begin
                  state_d = DRAIN;
`ifdef MIPI_CSI_RX_HEADER_ECC_EN
                  hdr_err_d = 1'b1;
`endif
               end else begin
                  pt_d = hdr_c.di[5:0];
                  vc_d = hdr_c.di[7:6];
                  wc_d = hdr_c.wc;
                  if (hdr_c.di[5:0] < LONG_DT_MIN) begin
                     fs_d    = (hdr_c.di[5:0] == DT_FS);
                     fe_d    = (hdr_c.di[5:0] == DT_FE);
                     state_d = DRAIN;
                  end else if (hdr_c.wc == '0) begin
                     state_d = DRAIN;
                  end else begin
                     rem_d   = hdr_c.wc;
                     state_d = PAYLOAD;
                  end
               end
            end
         end
         PAYLOAD: begin
            if (data_valid_i) begin
               out_valid_d = 1'b1;
               data_d      = stream_c;
               if (rem_q > WC_W'(BE_W)) begin
                  byte_en_d = '1;
                  rem_d     = rem_q - WC_W'(BE_W);
               end else begin
                  byte_en_d = tail_mask(rem_q[3:0]);
                  rem_d     = '0;
                  state_d   = DRAIN;
               end
            end else begin
               abort_d = 1'b1;
               rem_d   = '0;
               state_d = IDLE;
            end
         end
         DRAIN: begin
            if (!data_valid_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; valid history resets high so a word already
   // in flight at reset release is not mistaken for a packet start
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q      <= IDLE;
         valid_prev_q <= 1'b1;
         rem_q        <= '0;
         out_valid_q  <= 1'b0;
         data_q       <= '0;
         byte_en_q    <= '0;
         pt_q         <= '0;
         vc_q         <= '0;
         wc_q         <= '0;
         fs_q         <= 1'b0;
         fe_q         <= 1'b0;
         abort_q      <= 1'b0;
`ifdef MIPI_CSI_RX_HEADER_ECC_EN
         hdr_err_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         valid_prev_q <= valid_prev_d;
         rem_q        <= rem_d;
         out_valid_q  <= out_valid_d;
         data_q       <= data_d;
         byte_en_q    <= byte_en_d;
         pt_q         <= pt_d;
         vc_q         <= vc_d;
         wc_q         <= wc_d;
         fs_q         <= fs_d;
         fe_q         <= fe_d;
         abort_q      <= abort_d;
`ifdef MIPI_CSI_RX_HEADER_ECC_EN
         hdr_err_q    <= hdr_err_d;
`endif
      end
   end

   assign output_valid_o = out_valid_q;
   assign data_o         = data_q;
   assign byte_en_o      = byte_en_q;
   assign packet_type_o  = pt_q;
   assign vc_o           = vc_q;
   assign word_count_o   = wc_q;
   assign frame_start_o  = fs_q;
   assign frame_end_o    = fe_q;
   assign abort_o        = abort_q;

endmodule

// File: tb/tb_mipi_csi_rx_packet_decoder_16b4lane.sv
// Self-checking bench for the CSI-2 RX packet decoder: vector table fed
// through an expected-output queue, plus hand sequences for async reset
// and (when MIPI_CSI_RX_HEADER_ECC_EN is defined) header ECC errors.
module tb_mipi_csi_rx_packet_decoder_16b4lane;
   import mipi_csi_pkg::*;

   localparam logic [7:0] SB = 8'hB8;

   typedef struct {
      string       name;
      bit          valid;
      logic [63:0] din;
      bit          ov;
      logic [7:0]  be;
      logic [63:0] dout;
      bit          fs;
      bit          fe;
      bit          ab;
      bit          he;
      logic [5:0]  pt;
      logic [1:0]  vc;
      logic [15:0] wc;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        data_valid;
   logic [63:0] data_in;
   logic        output_valid;
   logic [63:0] data_out;
   logic [7:0]  byte_en;
   logic [5:0]  packet_type;
   logic [1:0]  vc;
   logic [15:0] word_count;
   logic        frame_start;
   logic        frame_end;
   logic        abort;
   logic        header_err;

   int          n_chk;
   int          n_pass;
   vec_t        vecs[$];
   vec_t        sb[$];
   logic [5:0]  cur_pt;
   logic [1:0]  cur_vc;
   logic [15:0] cur_wc;

   mipi_csi_rx_packet_decoder_16b4lane dut (
      .clk_i          (clk),
      .reset_n_i      (rst_n),
      .data_valid_i   (data_valid),
      .data_i         (data_in),
      .output_valid_o (output_valid),
      .data_o         (data_out),
      .byte_en_o      (byte_en),
      .packet_type_o  (packet_type),
      .vc_o           (vc),
      .word_count_o   (word_count),
      .frame_start_o  (frame_start),
      .frame_end_o    (frame_end),
`ifdef MIPI_CSI_RX_HEADER_ECC_EN
      .header_err_o   (header_err),
`endif
      .abort_o        (abort)
   );

`ifndef MIPI_CSI_RX_HEADER_ECC_EN
   assign header_err = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // CSI-2 header ECC, written out bit by bit from the standard parity table
   function automatic logic [5:0] ecc6(input logic [23:0] d);
      logic [5:0] e;
      e[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
      e[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
      e[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
      e[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
      e[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
      e[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
      return e;
   endfunction

   function automatic logic [63:0] hdr_word(input logic [7:0] di, input logic [15:0] wc);
      logic [7:0] ecc;
      ecc = {2'b00, ecc6({wc, di})};
      return {ecc, SB, wc[15:8], SB, wc[7:0], SB, di, SB};
   endfunction

   // Stream byte 4j+n travels as byte j of lane n
   function automatic logic [63:0] to_lanes(input logic [63:0] s);
      logic [63:0] w;
      w = '0;
      for (int n = 0; n < 4; n++)
         for (int j = 0; j < 2; j++)
            w[16*n+8*j +: 8] = s[8*(4*j+n) +: 8];
      return w;
   endfunction

   function automatic logic [63:0] pat(input int k);
      logic [63:0] s;
      for (int i = 0; i < 8; i++) s[8*i +: 8] = 8'(k*16 + i*3 + 1);
      return s;
   endfunction

   function automatic logic [63:0] be_mask(input logic [7:0] be);
      logic [63:0] m;
      for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{be[i]}};
      return m;
   endfunction

   task automatic add(input string nm, input bit v, input logic [63:0] din, input bit ov,
                      input logic [7:0] be, input logic [63:0] dout,
                      input bit fs, input bit fe, input bit ab, input bit he);
      vec_t e;
      e.name = nm; e.valid = v; e.din = din; e.ov = ov; e.be = be; e.dout = dout;
      e.fs = fs; e.fe = fe; e.ab = ab; e.he = he;
      e.pt = cur_pt; e.vc = cur_vc; e.wc = cur_wc;
      vecs.push_back(e);
   endtask

   task automatic idle(input string nm, input int n);
      for (int i = 0; i < n; i++) add(nm, 1'b0, 64'h0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_out(input vec_t e);
      logic        ok;
      logic [63:0] m;
      m  = be_mask(e.be);
      ok = (output_valid === e.ov) && (frame_start === e.fs) && (frame_end === e.fe) &&
           (abort === e.ab) && (header_err === e.he) && (packet_type === e.pt) &&
           (vc === e.vc) && (word_count === e.wc);
      if (e.ov) ok = ok && (byte_en === e.be) && ((data_out & m) === (e.dout & m));
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got ov=%0b be=%h d=%h fs=%0b fe=%0b ab=%0b he=%0b pt=%h vc=%0d wc=%0d; want ov=%0b be=%h d=%h fs=%0b fe=%0b ab=%0b he=%0b pt=%h vc=%0d wc=%0d",
                    e.name, output_valid, byte_en, data_out, frame_start, frame_end, abort, header_err,
                    packet_type, vc, word_count, e.ov, e.be, e.dout, e.fs, e.fe, e.ab, e.he, e.pt, e.vc, e.wc);
   endtask

   task automatic step(input vec_t e);
      data_valid = e.valid;
      data_in    = e.din;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out(sb.pop_front());
   endtask

   task automatic run_vecs();
      while (vecs.size() > 0) step(vecs.pop_front());
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, got, want);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_ov"},  64'(output_valid), 64'h0);
      chk({nm, "_be"},  64'(byte_en),      64'h0);
      chk({nm, "_d"},   data_out,          64'h0);
      chk({nm, "_pt"},  64'(packet_type),  64'h0);
      chk({nm, "_vc"},  64'(vc),           64'h0);
      chk({nm, "_wc"},  64'(word_count),   64'h0);
      chk({nm, "_pls"}, 64'({frame_start, frame_end, abort, header_err}), 64'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] w;
      n_chk = 0; n_pass = 0;
      cur_pt = '0; cur_vc = '0; cur_wc = '0;
      rst_n = 1'b0; data_valid = 1'b0; data_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      idle("idle", 2);
      // Frame start short packet
      add("fs_hdr", 1, 64'h00B800B800B800B8, 0, 8'h00, 64'h0, 1, 0, 0, 0);
      idle("fs_gap", 2);
      // Long RAW10, WC=20 -> FF, FF, 0F; footer ignored
      cur_pt = DT_RAW10; cur_vc = 2'd0; cur_wc = 16'd20;
      add("long_hdr", 1, hdr_word({2'b00, DT_RAW10}, 16'd20), 0, 8'h00, 64'h0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++)
         add("long_pl", 1, to_lanes(pat(k)), 1, (k == 2) ? 8'h0F : 8'hFF, pat(k), 0, 0, 0, 0);
      add("long_ftr", 1, 64'hDEADBEEF01234567, 0, 8'h00, 64'h0, 0, 0, 0, 0);
      add("long_ftr", 1, 64'hB8B8B8B8B8B8B8B8, 0, 8'h00, 64'h0, 0, 0, 0, 0);
      idle("long_gap", 1);
      // Bad sync on lane 2: nothing decoded, fields unchanged
      w = hdr_word({2'b00, DT_RAW12}, 16'd16);
      w[39:32] = 8'hB7;
      add("bad_sync", 1, w, 0, 8'h00, 64'h0, 0, 0, 0, 0);
      add("bad_sync_pl", 1, to_lanes(pat(3)), 0, 8'h00, 64'h0, 0, 0, 0, 0);
      add("bad_sync_pl", 1, to_lanes(pat(4)), 0, 8'h00, 64'h0, 0, 0, 0, 0);
      idle("bad_gap", 1);
      // Good packet after bad sync, VC 1, WC=3
      cur_pt = DT_RAW8; cur_vc = 2'd1; cur_wc = 16'd3;
      add("vc1_hdr", 1, hdr_word({2'b01, DT_RAW8}, 16'd3), 0, 8'h00, 64'h0, 0, 0, 0, 0);
      add("vc1_pl", 1, to_lanes(pat(5)), 1, 8'h07, pat(5), 0, 0, 0, 0);
      idle("vc1_gap", 1);
      // Abort after 3 of 8 payload words
      cur_pt = DT_RAW12; cur_vc = 2'd0; cur_wc = 16'd64;
      add("abort_hdr", 1, hdr_word({2'b00, DT_RAW12}, 16'd64), 0, 8'h00, 64'h0, 0, 0, 0, 0);
      for (int k = 6; k < 9; k++)
         add("abort_pl", 1, to_lanes(pat(k)), 1, 8'hFF, pat(k), 0, 0, 0, 0);
      add("abort", 0, 64'h0, 0, 8'h00, 64'h0, 0, 0, 1, 0);
      idle("post_abort", 1);
      // Back-to-back: FE, one idle cycle, RAW8 WC=8
      cur_pt = DT_FE; cur_wc = 16'd0;
      add("fe_hdr", 1, hdr_word({2'b00, DT_FE}, 16'd0), 0, 8'h00, 64'h0, 0, 1, 0, 0);
      idle("b2b_gap", 1);
      cur_pt = DT_RAW8; cur_wc = 16'd8;
      add("raw8_hdr", 1, hdr_word({2'b00, DT_RAW8}, 16'd8), 0, 8'h00, 64'h0, 0, 0, 0, 0);
      add("raw8_pl", 1, to_lanes(pat(9)), 1, 8'hFF, pat(9), 0, 0, 0, 0);
      add("raw8_ftr", 1, to_lanes(pat(10)), 0, 8'h00, 64'h0, 0, 0, 0, 0);
      idle("raw8_gap", 1);
      // Long packet with WC=0: header latched, no payload
      cur_pt = DT_RAW10; cur_wc = 16'd0;
      add("wc0_hdr", 1, hdr_word({2'b00, DT_RAW10}, 16'd0), 0, 8'h00, 64'h0, 0, 0, 0, 0);
      add("wc0_junk", 1, to_lanes(pat(11)), 0, 8'h00, 64'h0, 0, 0, 0, 0);
      idle("wc0_gap", 1);
      // Other short DT: no pulse
      cur_pt = 6'h02; cur_vc = 2'd2; cur_wc = 16'h1234;
      add("ls_hdr", 1, hdr_word(8'h82, 16'h1234), 0, 8'h00, 64'h0, 0, 0, 0, 0);
      idle("ls_gap", 1);
      // WC=9 -> FF, 01
      cur_pt = DT_RAW12; cur_vc = 2'd0; cur_wc = 16'd9;
      add("wc9_hdr", 1, hdr_word({2'b00, DT_RAW12}, 16'd9), 0, 8'h00, 64'h0, 0, 0, 0, 0);
      add("wc9_pl0", 1, to_lanes(pat(12)), 1, 8'hFF, pat(12), 0, 0, 0, 0);
      add("wc9_pl1", 1, to_lanes(pat(13)), 1, 8'h01, pat(13), 0, 0, 0, 0);
      idle("wc9_gap", 1);
      // WC=16, VC 3 -> exactly two full words
      cur_pt = DT_RAW10; cur_vc = 2'd3; cur_wc = 16'd16;
      add("wc16_hdr", 1, hdr_word({2'b11, DT_RAW10}, 16'd16), 0, 8'h00, 64'h0, 0, 0, 0, 0);
      add("wc16_pl0", 1, to_lanes(pat(14)), 1, 8'hFF, pat(14), 0, 0, 0, 0);
      add("wc16_pl1", 1, to_lanes(pat(15)), 1, 8'hFF, pat(15), 0, 0, 0, 0);
      add("wc16_ftr", 1, 64'h0123456789ABCDEF, 0, 8'h00, 64'h0, 0, 0, 0, 0);
      idle("wc16_gap", 1);
      run_vecs();

      // Asynchronous reset mid-payload, valid held high across release
      cur_pt = DT_RAW8; cur_vc = 2'd0; cur_wc = 16'd32;
      add("rst_hdr", 1, hdr_word({2'b00, DT_RAW8}, 16'd32), 0, 8'h00, 64'h0, 0, 0, 0, 0);
      add("rst_pl", 1, to_lanes(pat(16)), 1, 8'hFF, pat(16), 0, 0, 0, 0);
      run_vecs();
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      cur_pt = '0; cur_vc = '0; cur_wc = '0;
      add("post_rst_pl", 1, to_lanes(pat(17)), 0, 8'h00, 64'h0, 0, 0, 0, 0);
      add("post_rst_pl", 1, hdr_word({2'b00, DT_RAW8}, 16'd8), 0, 8'h00, 64'h0, 0, 0, 0, 0);
      idle("post_rst_gap", 1);
      add("post_rst_fs", 1, hdr_word(8'h00, 16'd0), 0, 8'h00, 64'h0, 1, 0, 0, 0);
      idle("post_rst_end", 1);
      run_vecs();

`ifdef MIPI_CSI_RX_HEADER_ECC_EN
      // Corrupted WC bit: error pulse, no payload, fields unchanged
      w = hdr_word({2'b00, DT_RAW10}, 16'd20);
      w[27] = ~w[27];
      add("ecc_bad", 1, w, 0, 8'h00, 64'h0, 0, 0, 0, 1);
      add("ecc_bad_pl", 1, to_lanes(pat(18)), 0, 8'h00, 64'h0, 0, 0, 0, 0);
      idle("ecc_bad_gap", 1);
      // ECC[7:6] non-zero
      w = hdr_word({2'b00, DT_FS}, 16'd0);
      w[62] = 1'b1;
      add("ecc_hi", 1, w, 0, 8'h00, 64'h0, 0, 0, 0, 1);
      idle("ecc_hi_gap", 1);
      // Correct ECC decodes normally
      cur_pt = DT_RAW10; cur_wc = 16'd4;
      add("ecc_ok_hdr", 1, hdr_word({2'b00, DT_RAW10}, 16'd4), 0, 8'h00, 64'h0, 0, 0, 0, 0);
      add("ecc_ok_pl", 1, to_lanes(pat(19)), 1, 8'h0F, pat(19), 0, 0, 0, 0);
      idle("ecc_ok_gap", 1);
      run_vecs();
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mipi_csi_rx_packet_decoder_16b4lane.md
Name: mipi_csi_rx_packet_decoder_16b4lane

Overview:
- Sits directly downstream of the 4-lane, 16-bit-per-lane lane aligner; consumes its aligned 64-bit lane word plus valid.
- Checks the per-lane sync bytes and parses the CSI-2 packet header (DI, WC, ECC).
- Streams long-packet payload as 8-byte words with byte enables; signals frame start/end from short packets.
- Discards the trailing CRC/footer and any garbage until the aligner's valid drops.

Parameters:
- SYNC_BYTE, 8'hB8, expected sync byte at the start of every lane.
- LONG_DT_MIN, 6'h10, lowest data type treated as a long packet.

Ports:
- clk_i  in  1  byte clock shared with lane aligner.
- reset_n_i  in  1  asynchronous active-low reset.
- data_valid_i  in  1  aligned lane word valid from lane aligner.
- data_i  in  64  aligned word; lane n = bits [16n+15:16n], earlier byte in the low half.
- output_valid_o  out  1  payload word valid.
- data_o  out  64  payload bytes; byte k = bits [8k+7:8k], in stream order.
- byte_en_o  out  8  valid bytes of data_o (contiguous from bit 0).
- packet_type_o  out  6  data type of the current packet; held until the next header.
- vc_o  out  2  virtual channel of the current packet.
- word_count_o  out  16  WC field of the current packet.
- frame_start_o  out  1  one-cycle pulse on a short packet with DT 0x00.
- frame_end_o  out  1  one-cycle pulse on a short packet with DT 0x01.
- abort_o  out  1  one-cycle pulse when valid drops mid-payload.

Behaviour:
- Reset: all outputs 0; state IDLE; remaining counter 0.
- Word layout on the first valid cycle:
  - Low byte of every lane must equal SYNC_BYTE.
  - High bytes: lane0 = DI, lane1 = WC[7:0], lane2 = WC[15:8], lane3 = ECC.
- IDLE: on the rising edge of data_valid_i (valid=1, previous valid=0), check all four sync bytes.
  - Any mismatch: go to DRAIN.
  - Otherwise: register DI[5:0] -> packet_type_o, DI[7:6] -> vc_o, WC -> word_count_o.
- Short packet (DT < LONG_DT_MIN):
  - DT 0x00 pulses frame_start_o and DT 0x01 pulses frame_end_o, one cycle after the header cycle.
  - Other short DTs produce no pulse.
  - Then go to DRAIN.
- Long packet:
  - WC == 0: go to DRAIN.
  - WC > 0: load remaining = WC and go to PAYLOAD.
- PAYLOAD, each cycle with data_valid_i = 1:
  - Output data_i, reordered: lane byte order becomes stream order. Stream byte 4j+n = lane n byte j (j = 0 low, 1 high).
  - output_valid_o = 1, with one cycle of registered latency.
  - remaining > 8: byte_en_o = 8'hFF, remaining -= 8.
  - remaining <= 8: byte_en_o = (1 << remaining) - 1 (8'hFF when remaining = 8), then go to DRAIN.
- PAYLOAD with data_valid_i = 0: pulse abort_o, output_valid_o = 0, go to IDLE.
- DRAIN: ignore data until data_valid_i = 0, then go to IDLE.
  - A valid dropping and rising in consecutive cycles is handled: IDLE sees the rising edge.
- Arithmetic: remaining is 16 bits. Payload words emitted = ceil(WC/8); the maximum WC of 65535 gives 8192 words.
- Asynchronous reset mid-packet: outputs clear immediately; the next packet needs a new rising edge of valid.

Optional Feature:
- Macro: MIPI_CSI_RX_HEADER_ECC_EN.
- Defined:
  - Compute the CSI-2 6-bit Hamming ECC over {WC, DI} on the header cycle.
  - On mismatch, or if ECC[7:6] != 0: go to DRAIN, emit no pulses and no payload, leave packet_type_o/vc_o/word_count_o unchanged.
  - Pulse the extra output header_err_o (1 bit, reset 0) for one cycle.
- Undefined:
  - ECC byte ignored; the header_err_o port is absent.

Decomposition:
- Shared package mipi_csi_pkg:
  - SYNC_BYTE.
  - Data-type constants: DT_FS = 6'h00, DT_FE = 6'h01, DT_RAW8 = 6'h2A, DT_RAW10 = 6'h2B, DT_RAW12 = 6'h2C.
  - State enum: IDLE, PAYLOAD, DRAIN.
  - Lane/byte width constants.
- Sub-module: mipi_csi_header_ecc, a combinational 24-bit -> 6-bit ECC generator, instantiated only under the macro.

Test Plan:
- Sync/FS: valid rises with word 64'h00B800B800B800B8 (DI = 0x00 on lane0) -> frame_start_o pulses once, 1 cycle later; no output_valid_o.
- Long packet:
  - Header: DI = 0x2B, WC = 20, lanes 0x2BB8, 0x14B8, 0x00B8, ECC lane.
  - Followed by 3 payload words -> output_valid_o for 3 cycles; byte_en_o = FF, FF, 0F; bytes in stream order.
  - Footer words while valid stays high are ignored.
- Bad sync: lane2 low byte = 0xB7 -> no outputs; the next good packet after valid drops decodes normally.
- Abort: WC = 64, valid drops after 3 payload words -> abort_o pulses once; output_valid_o = 0; IDLE.
- Back-to-back: valid low exactly one cycle between FE short packet (DI = 0x01) and long RAW8 with WC = 8 -> frame_end_o pulse, then one word with byte_en_o = FF.
- ECC (macro on): corrupt one WC bit -> header_err_o pulse, no payload; correct ECC -> normal decode.
